// File: rtl/main_slave_loader_ctrl_if.sv
//------------------------------------------------------------------------------
// Module    : main_slave_loader_ctrl_if
// Brief     : Bus bundle between the loader controller and its environment:
//             preload byte stream, run control/status and the slave RAM port
//             of the HLS `main` accelerator.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface main_slave_loader_ctrl_if;
    // run control / status
    logic         run_go;
    logic         busy;
    logic         run_done;
    logic         timeout;
    logic [31:0]  cycle_count;
    logic [15:0]  load_checksum;

    // preload byte stream
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;

    // accelerator start/done
    logic         start_port;
    logic         done_port;

    // slave RAM port of `main`
    logic [1:0]   S_oe_ram;
    logic [1:0]   S_we_ram;
    logic [19:0]  S_addr_ram;
    logic [127:0] S_Wdata_ram;
    logic [13:0]  S_data_ram_size;
    logic [1:0]   Sout_DataRdy;
    logic [127:0] Sout_Rdata_ram;

    // controller side
    modport master (
        input  run_go, in_byte, in_valid, done_port, Sout_DataRdy, Sout_Rdata_ram,
        output in_ready, start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram,
               S_data_ram_size, busy, run_done, timeout, cycle_count, load_checksum
    );

    // environment side (byte source, accelerator, host)
    modport slave (
        output run_go, in_byte, in_valid, done_port, Sout_DataRdy, Sout_Rdata_ram,
        input  in_ready, start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram,
               S_data_ram_size, busy, run_done, timeout, cycle_count, load_checksum
    );
endinterface

`default_nettype wire

// File: rtl/main_slave_loader_ctrl.sv
//------------------------------------------------------------------------------
// Module    : main_slave_loader_ctrl
// Brief     : Preloads MEM_BYTES bytes from a valid/ready byte stream into the
//             `main` accelerator through its slave RAM port (32-bit packed
//             writes), pulses start_port, then measures the run length until
//             done_port or a timeout.
//             Optional build macro LOADER_CHECKSUM_EN: 16-bit sum of accepted
//             bytes on load_checksum plus one read-back of the word at
//             BASE_ADDR after completion.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module main_slave_loader_ctrl #(
    parameter int          MEM_BYTES      = 256,
    parameter logic [9:0]  BASE_ADDR      = 10'd0,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd200000000
) (
    input  wire logic              clock,
    input  wire logic              reset,
    main_slave_loader_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WRITE = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5,
        S_TOUT  = 3'd6,
        S_READ  = 3'd7
    } state_t;

    localparam logic [10:0] c_mem_bytes = 11'(MEM_BYTES);

`ifdef LOADER_CHECKSUM_EN
    // completion first reads back the word at BASE_ADDR
    localparam state_t c_done_target = S_READ;
`else
    localparam state_t c_done_target = S_DONE;
`endif

    state_t       r_state;
    state_t       w_next;
    logic [10:0]  r_byte_cnt;
    logic [31:0]  r_pack;
    logic [31:0]  r_cnt;
    logic [31:0]  r_cycle_count;

    logic         w_accept;
    logic [10:0]  w_byte_cnt_nxt;
    logic [10:0]  w_last_idx;
    logic [9:0]   w_word_addr;
    logic [2:0]   w_lanes;
    logic [6:0]   w_wr_size;
    logic [31:0]  w_cnt_inc;
    logic         w_go;

    // handshake and bookkeeping helpers
    assign w_accept       = (r_state == S_FILL) && bus.in_valid;
    assign w_byte_cnt_nxt = r_byte_cnt + 11'd1;
    assign w_go           = bus.run_go &&
                            ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_TOUT));

    // The word being written holds the most recently accepted byte; its
    // first byte index is that byte's index rounded down to a multiple of 4.
    assign w_last_idx  = r_byte_cnt - 11'd1;
    assign w_word_addr = BASE_ADDR + {w_last_idx[9:2], 2'b00};
    assign w_lanes     = (r_byte_cnt[1:0] == 2'd0) ? 3'd4 : {1'b0, r_byte_cnt[1:0]};
    assign w_wr_size   = {1'b0, w_lanes, 3'b000};

    // run counter saturates instead of wrapping
    assign w_cnt_inc = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : (r_cnt + 32'd1);

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_TOUT: begin
                if (bus.run_go) w_next = S_FILL;
            end
            S_FILL: begin
                if (w_accept && ((r_byte_cnt[1:0] == 2'd3) || (w_byte_cnt_nxt == c_mem_bytes)))
                    w_next = S_WRITE;
            end
            S_WRITE: begin
                if (bus.Sout_DataRdy[0])
                    w_next = (r_byte_cnt == c_mem_bytes) ? S_START : S_FILL;
            end
            S_START: begin
                if (bus.done_port)                    w_next = c_done_target;
                else if (TIMEOUT_CYCLES <= 32'd1)     w_next = S_TOUT;
                else                                  w_next = S_RUN;
            end
            S_RUN: begin
                // done wins over a timeout landing in the same cycle
                if (bus.done_port)                    w_next = c_done_target;
                else if (w_cnt_inc >= TIMEOUT_CYCLES) w_next = S_TOUT;
            end
`ifdef LOADER_CHECKSUM_EN
            S_READ: begin
                if (bus.Sout_DataRdy[0]) w_next = S_DONE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // output decode; every output is a function of registered state only
    always_comb begin
        bus.in_ready        = 1'b0;
        bus.start_port      = 1'b0;
        bus.S_oe_ram        = 2'b00;
        bus.S_we_ram        = 2'b00;
        bus.S_addr_ram      = 20'd0;
        bus.S_Wdata_ram     = 128'd0;
        bus.S_data_ram_size = 14'd0;
        bus.busy            = 1'b0;
        bus.run_done        = 1'b0;
        bus.timeout         = 1'b0;
        case (r_state)
            S_FILL: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
            end
            S_WRITE: begin
                bus.S_we_ram        = 2'b01;
                bus.S_addr_ram      = {10'd0, w_word_addr};
                bus.S_Wdata_ram     = {96'd0, r_pack};
                bus.S_data_ram_size = {7'd0, w_wr_size};
                bus.busy            = 1'b1;
            end
            S_START: begin
                bus.start_port = 1'b1;
                bus.busy       = 1'b1;
            end
            S_RUN: begin
                bus.busy = 1'b1;
            end
            S_DONE: begin
                bus.run_done = 1'b1;
            end
            S_TOUT: begin
                bus.run_done = 1'b1;
                bus.timeout  = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_READ: begin
                bus.S_oe_ram        = 2'b01;
                bus.S_addr_ram      = {10'd0, BASE_ADDR};
                bus.S_data_ram_size = 14'd32;
                bus.busy            = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // byte packing, run counter and captured run length
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_byte_cnt    <= 11'd0;
            r_pack        <= 32'd0;
            r_cnt         <= 32'd0;
            r_cycle_count <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_TOUT: begin
                    if (w_go) begin
                        r_byte_cnt    <= 11'd0;
                        r_pack        <= 32'd0;
                        r_cnt         <= 32'd0;
                        r_cycle_count <= 32'd0;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_pack[8*r_byte_cnt[1:0] +: 8] <= bus.in_byte;
                        r_byte_cnt                     <= w_byte_cnt_nxt;
                    end
                end
                S_WRITE: begin
                    // empty lanes of the next word must read as zero
                    if (bus.Sout_DataRdy[0]) r_pack <= 32'd0;
                end
                S_START: begin
                    r_cnt <= 32'd1;
                    if (bus.done_port)                 r_cycle_count <= 32'd1;
                    else if (TIMEOUT_CYCLES <= 32'd1)  r_cycle_count <= TIMEOUT_CYCLES;
                end
                S_RUN: begin
                    r_cnt <= w_cnt_inc;
                    if (bus.done_port)                    r_cycle_count <= w_cnt_inc;
                    else if (w_cnt_inc >= TIMEOUT_CYCLES) r_cycle_count <= TIMEOUT_CYCLES;
                end
                default: ;
            endcase
        end
    end

    assign bus.cycle_count = r_cycle_count;

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] r_checksum;
    logic [31:0] r_result;

    // running byte sum and read-back capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_checksum <= 16'd0;
            r_result   <= 32'd0;
        end else begin
            if (w_go)
                r_checksum <= 16'd0;
            else if (w_accept)
                r_checksum <= r_checksum + {8'd0, bus.in_byte};
            if ((r_state == S_READ) && bus.Sout_DataRdy[0])
                r_result <= bus.Sout_Rdata_ram[31:0];
        end
    end

    assign bus.load_checksum = r_checksum;

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, w_last_idx[10], w_last_idx[1:0], bus.Sout_DataRdy[1],
                           bus.Sout_Rdata_ram[127:32], r_result};
`else
    assign bus.load_checksum = 16'd0;

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, w_last_idx[10], w_last_idx[1:0], bus.Sout_DataRdy[1],
                           bus.Sout_Rdata_ram};
`endif

endmodule

`default_nettype wire

// File: tb/tb_main_slave_loader_ctrl.sv
//------------------------------------------------------------------------------
// Module    : tb_main_slave_loader_ctrl
// Brief     : Self-checking bench for main_slave_loader_ctrl. Three instances
//             cover MEM_BYTES=256, a 6-byte partial-word/short-timeout build
//             and a wrapping base address; randomized byte streams, DataRdy
//             latencies and done timing are checked against a reference model.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_main_slave_loader_ctrl;

    typedef struct packed {
        logic [19:0]  addr;
        logic [127:0] data;
        logic [13:0]  size;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // shared stimulus; only run_go is steered to the instance under test
    logic         d_run_go   = 1'b0;
    logic         d_in_valid = 1'b0;
    logic         d_done     = 1'b0;
    logic [7:0]   d_in_byte  = 8'd0;
    logic [1:0]   d_rdy      = 2'b00;
    logic [127:0] d_rdata    = 128'd0;
    int           sel        = 0;

    main_slave_loader_ctrl_if ifa ();
    main_slave_loader_ctrl_if ifb ();
    main_slave_loader_ctrl_if ifc ();

    assign ifa.run_go = d_run_go && (sel == 0);
    assign ifb.run_go = d_run_go && (sel == 1);
    assign ifc.run_go = d_run_go && (sel == 2);
    assign ifa.in_byte = d_in_byte;   assign ifb.in_byte = d_in_byte;   assign ifc.in_byte = d_in_byte;
    assign ifa.in_valid = d_in_valid; assign ifb.in_valid = d_in_valid; assign ifc.in_valid = d_in_valid;
    assign ifa.done_port = d_done;    assign ifb.done_port = d_done;    assign ifc.done_port = d_done;
    assign ifa.Sout_DataRdy = d_rdy;  assign ifb.Sout_DataRdy = d_rdy;  assign ifc.Sout_DataRdy = d_rdy;
    assign ifa.Sout_Rdata_ram = d_rdata; assign ifb.Sout_Rdata_ram = d_rdata; assign ifc.Sout_Rdata_ram = d_rdata;

    main_slave_loader_ctrl #(.MEM_BYTES(256), .BASE_ADDR(10'd0),   .TIMEOUT_CYCLES(32'd1000))
        dut_a (.clock(clock), .reset(reset), .bus(ifa));
    main_slave_loader_ctrl #(.MEM_BYTES(6),   .BASE_ADDR(10'd0),   .TIMEOUT_CYCLES(32'd5))
        dut_b (.clock(clock), .reset(reset), .bus(ifb));
    main_slave_loader_ctrl #(.MEM_BYTES(9),   .BASE_ADDR(10'h3F8), .TIMEOUT_CYCLES(32'd20))
        dut_c (.clock(clock), .reset(reset), .bus(ifc));

    // outputs of the instance under test
    logic         o_in_ready, o_start, o_busy, o_run_done, o_timeout;
    logic [1:0]   o_oe, o_we;
    logic [19:0]  o_addr;
    logic [127:0] o_wdata;
    logic [13:0]  o_size;
    logic [31:0]  o_cc;
    logic [15:0]  o_cs;
    logic [218:0] o_all;

    always_comb begin
        case (sel)
            1: begin
                o_in_ready = ifb.in_ready; o_start = ifb.start_port; o_busy = ifb.busy;
                o_run_done = ifb.run_done; o_timeout = ifb.timeout; o_oe = ifb.S_oe_ram;
                o_we = ifb.S_we_ram; o_addr = ifb.S_addr_ram; o_wdata = ifb.S_Wdata_ram;
                o_size = ifb.S_data_ram_size; o_cc = ifb.cycle_count; o_cs = ifb.load_checksum;
            end
            2: begin
                o_in_ready = ifc.in_ready; o_start = ifc.start_port; o_busy = ifc.busy;
                o_run_done = ifc.run_done; o_timeout = ifc.timeout; o_oe = ifc.S_oe_ram;
                o_we = ifc.S_we_ram; o_addr = ifc.S_addr_ram; o_wdata = ifc.S_Wdata_ram;
                o_size = ifc.S_data_ram_size; o_cc = ifc.cycle_count; o_cs = ifc.load_checksum;
            end
            default: begin
                o_in_ready = ifa.in_ready; o_start = ifa.start_port; o_busy = ifa.busy;
                o_run_done = ifa.run_done; o_timeout = ifa.timeout; o_oe = ifa.S_oe_ram;
                o_we = ifa.S_we_ram; o_addr = ifa.S_addr_ram; o_wdata = ifa.S_Wdata_ram;
                o_size = ifa.S_data_ram_size; o_cc = ifa.cycle_count; o_cs = ifa.load_checksum;
            end
        endcase
    end
    assign o_all = {o_in_ready, o_start, o_oe, o_we, o_addr, o_wdata, o_size,
                    o_busy, o_run_done, o_timeout, o_cc, o_cs};

    // bench state
    logic [7:0] stim [0:1023];
    wr_t        obs [$];
    int         n_start, n_extra_start, n_stall_err, n_ready_err, n_oe_err, n_accepted;
    bit         bound_hit;
    logic [2:0] post_go_flags;
    int         n_cmp = 0;
    int         n_err = 0;

    // ---------------- reference model ----------------
    function automatic wr_t model_write(input int w, input int n, input logic [9:0] base);
        wr_t        r;
        int         lanes;
        logic [9:0] a;
        r     = '0;
        lanes = (n - 4*w >= 4) ? 4 : (n - 4*w);
        a     = base + 10'(4*w);
        r.addr = {10'd0, a};
        for (int l = 0; l < lanes; l++) r.data[8*l +: 8] = stim[4*w + l];
        r.size = 14'(8*lanes);
        return r;
    endfunction

    function automatic logic [31:0] model_cc(input int d, input int tmo);
        return (d >= 0 && d + 1 <= tmo) ? 32'(d + 1) : 32'(tmo);
    endfunction

    function automatic logic [15:0] model_sum(input int n);
`ifdef LOADER_CHECKSUM_EN
        logic [15:0] s = 16'd0;
        for (int i = 0; i < n; i++) s = s + {8'd0, stim[i]};
        return s;
`else
        return (n < 0) ? 16'hFFFF : 16'd0;
`endif
    endfunction

    // ---------------- stimulus drivers (no checking) ----------------
    // Pulse run_go, stream n bytes, answer writes after rdy_delay cycles
    // (-1: random 0..3 per write); returns on the start pulse or the budget.
    task automatic load_phase(input int n, input bit hold_valid, input int rdy_delay, input int budget);
        int  cyc = 0, wait_c = 0, cur_dly = 0;
        bit  prev_we = 1'b0;
        wr_t held = '0;
        obs.delete();
        n_start = 0; n_stall_err = 0; n_ready_err = 0; n_oe_err = 0; n_accepted = 0; bound_hit = 1'b0;
        @(negedge clock); d_run_go = 1'b1;
        @(negedge clock); d_run_go = 1'b0;
        post_go_flags = {o_run_done, o_timeout, o_busy};
        forever begin
            if (o_start) begin n_start++; break; end
            if (o_we[0]) begin
                if (o_in_ready) n_ready_err++;
                if (prev_we && ({o_addr, o_wdata, o_size} !== held)) n_stall_err++;
                if (!prev_we) begin
                    wait_c  = 0;
                    cur_dly = (rdy_delay < 0) ? int'($urandom_range(0, 3)) : rdy_delay;
                end
                held    = {o_addr, o_wdata, o_size};
                prev_we = 1'b1;
                if (wait_c == cur_dly) begin
                    d_rdy = 2'b01; obs.push_back(held); prev_we = 1'b0;
                end else begin
                    d_rdy = 2'b00; wait_c++;
                end
            end else begin
                d_rdy = 2'b00; prev_we = 1'b0;
            end
            if (o_oe !== 2'b00) n_oe_err++;
            d_in_valid = (n_accepted < n) && (hold_valid || ($urandom_range(0, 2) != 0));
            d_in_byte  = d_in_valid ? stim[n_accepted] : 8'($urandom);
            if (o_in_ready && d_in_valid) n_accepted++;
            @(negedge clock);
            cyc++;
            if (cyc > budget) begin bound_hit = 1'b1; break; end
        end
        d_in_valid = 1'b0;
        d_rdy      = 2'b00;
    endtask

    // Called on the start-pulse cycle; raises done_port d cycles later (d<0: never).
    task automatic run_phase(input int d, input int budget);
        int k = 0;
        n_extra_start = 0;
        forever begin
            d_done = (k == d);
            d_rdy  = {1'b0, o_oe[0]};
            @(negedge clock);
            if (o_start) n_extra_start++;
            if (o_run_done) break;
            k++;
            if (k > budget) begin bound_hit = 1'b1; break; end
        end
        d_done = 1'b0;
        d_rdy  = 2'b00;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            n_cmp++;
            if (o_all !== '0) begin
                n_err++; $display("FAIL reset_outputs_dut%0d: got %h, want 0", s, o_all);
            end
        end
        @(negedge clock); reset = 1'b1;
        sel = 0;
    endtask

    task automatic test_load_256;
        wr_t e;
        sel = 0;
        for (int i = 0; i < 256; i++) stim[i] = 8'(i);
        load_phase(256, 1'b0, 1, 5000);
        run_phase(10, 200);
        n_cmp++;
        if (bound_hit || obs.size() != 64 || n_start != 1) begin
            n_err++; $display("FAIL load256_count: got writes=%0d starts=%0d bound=%0d, want 64/1/0", obs.size(), n_start, bound_hit);
        end
        n_cmp++;
        if (obs.size() > 0 && obs[0] !== {20'd0, 128'h03020100, 14'd32}) begin
            n_err++; $display("FAIL load256_first: got %h, want addr 0 data 03020100 size 32", obs[0]);
        end
        n_cmp++;
        if (obs.size() == 64 && obs[63] !== {20'd252, 128'hFFFEFDFC, 14'd32}) begin
            n_err++; $display("FAIL load256_last: got %h, want addr 252 data FFFEFDFC size 32", obs[63]);
        end
        for (int w = 0; w < obs.size(); w++) begin
            e = model_write(w, 256, 10'd0);
            n_cmp++;
            if (obs[w] !== e) begin
                n_err++; $display("FAIL load256_write%0d: got %h, want %h", w, obs[w], e);
            end
        end
        n_cmp++;
        if ({n_stall_err, n_ready_err, n_oe_err, n_extra_start} !== 128'd0) begin
            n_err++; $display("FAIL load256_bus: got stall=%0d ready=%0d oe=%0d extra_start=%0d, want 0", n_stall_err, n_ready_err, n_oe_err, n_extra_start);
        end
        n_cmp++;
        if ({o_run_done, o_timeout, o_busy} !== 3'b100 || o_cc !== 32'd11) begin
            n_err++; $display("FAIL done10_status: got done/tout/busy=%b cc=%0d, want 100 cc=11", {o_run_done, o_timeout, o_busy}, o_cc);
        end
        n_cmp++;
        if (o_cs !== model_sum(256)) begin
            n_err++; $display("FAIL load256_checksum: got %h, want %h", o_cs, model_sum(256));
        end
    endtask

    task automatic test_partial_word;
        sel = 1;
        for (int i = 0; i < 6; i++) stim[i] = 8'(8'h11 + i);
        load_phase(6, 1'b0, 1, 200);
        run_phase(0, 50);
        n_cmp++;
        if (bound_hit || obs.size() != 2) begin
            n_err++; $display("FAIL partial_count: got writes=%0d bound=%0d, want 2/0", obs.size(), bound_hit);
        end else begin
            n_cmp++;
            if (obs[0] !== {20'd0, 128'h14131211, 14'd32}) begin
                n_err++; $display("FAIL partial_w0: got %h, want addr 0 data 14131211 size 32", obs[0]);
            end
            n_cmp++;
            if (obs[1] !== {20'd4, 128'h1615, 14'd16}) begin
                n_err++; $display("FAIL partial_w1: got %h, want addr 4 data 00001615 size 16", obs[1]);
            end
        end
        n_cmp++;
        if ({o_run_done, o_timeout} !== 2'b10 || o_cc !== 32'd1) begin
            n_err++; $display("FAIL done_in_start: got done/tout=%b cc=%0d, want 10 cc=1", {o_run_done, o_timeout}, o_cc);
        end
    endtask

    task automatic test_timeout;
        sel = 1;
        for (int i = 0; i < 6; i++) stim[i] = 8'($urandom);
        load_phase(6, 1'b0, -1, 200);
        run_phase(-1, 50);
        n_cmp++;
        if (bound_hit || {o_run_done, o_timeout, o_busy} !== 3'b110 || o_cc !== 32'd5) begin
            n_err++; $display("FAIL timeout_status: got done/tout/busy=%b cc=%0d bound=%0d, want 110 cc=5", {o_run_done, o_timeout, o_busy}, o_cc, bound_hit);
        end
        d_done = 1'b1;
        repeat (3) @(negedge clock);
        d_done = 1'b0;
        n_cmp++;
        if ({o_run_done, o_timeout} !== 2'b11 || o_cc !== 32'd5) begin
            n_err++; $display("FAIL timeout_hold: got done/tout=%b cc=%0d, want 11 cc=5", {o_run_done, o_timeout}, o_cc);
        end
        // done in the very cycle the timeout would fire
        load_phase(6, 1'b0, -1, 200);
        n_cmp++;
        if (post_go_flags !== 3'b001) begin
            n_err++; $display("FAIL timeout_cleared_by_go: got done/tout/busy=%b, want 001", post_go_flags);
        end
        run_phase(4, 50);
        n_cmp++;
        if (bound_hit || {o_run_done, o_timeout} !== 2'b10 || o_cc !== 32'd5) begin
            n_err++; $display("FAIL done_beats_timeout: got done/tout=%b cc=%0d, want 10 cc=5", {o_run_done, o_timeout}, o_cc);
        end
    endtask

    task automatic test_stall;
        wr_t e;
        int  d;
        sel = 0;
        for (int i = 0; i < 256; i++) stim[i] = 8'($urandom);
        d = int'($urandom_range(0, 30));
        load_phase(256, 1'b1, 3, 5000);
        run_phase(d, 200);
        n_cmp++;
        if (bound_hit || obs.size() != 64 || n_accepted != 256) begin
            n_err++; $display("FAIL stall_count: got writes=%0d bytes=%0d bound=%0d, want 64/256/0", obs.size(), n_accepted, bound_hit);
        end
        n_cmp++;
        if (n_stall_err != 0 || n_ready_err != 0) begin
            n_err++; $display("FAIL stall_bus_stable: got unstable=%0d ready_in_write=%0d, want 0/0", n_stall_err, n_ready_err);
        end
        for (int w = 0; w < obs.size(); w++) begin
            e = model_write(w, 256, 10'd0);
            n_cmp++;
            if (obs[w] !== e) begin
                n_err++; $display("FAIL stall_write%0d: got %h, want %h", w, obs[w], e);
            end
        end
        n_cmp++;
        if (o_cc !== model_cc(d, 1000) || o_timeout !== 1'b0) begin
            n_err++; $display("FAIL stall_cc: got cc=%0d tout=%b, want cc=%0d tout=0", o_cc, o_timeout, model_cc(d, 1000));
        end
    endtask

    task automatic test_random_wrap;
        wr_t e;
        int  d;
        sel = 2;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 9; i++) stim[i] = 8'($urandom);
            d = int'($urandom_range(0, 25));
            load_phase(9, 1'b0, -1, 300);
            run_phase(d, 100);
            n_cmp++;
            if (bound_hit || obs.size() != 3) begin
                n_err++; $display("FAIL wrap%0d_count: got writes=%0d bound=%0d, want 3/0", it, obs.size(), bound_hit);
            end
            for (int w = 0; w < obs.size(); w++) begin
                e = model_write(w, 9, 10'h3F8);
                n_cmp++;
                if (obs[w] !== e) begin
                    n_err++; $display("FAIL wrap%0d_write%0d: got %h, want %h", it, w, obs[w], e);
                end
            end
            n_cmp++;
            if (o_cc !== model_cc(d, 20) || o_timeout !== (d + 1 > 20) || o_run_done !== 1'b1) begin
                n_err++; $display("FAIL wrap%0d_run: got cc=%0d tout=%b done=%b, want cc=%0d tout=%b done=1", it, o_cc, o_timeout, o_run_done, model_cc(d, 20), (d + 1 > 20));
            end
            n_cmp++;
            if (o_cs !== model_sum(9)) begin
                n_err++; $display("FAIL wrap%0d_checksum: got %h, want %h", it, o_cs, model_sum(9));
            end
        end
    endtask

    task automatic test_reset_mid_write;
        wr_t e;
        sel = 0;
        for (int i = 0; i < 256; i++) stim[i] = 8'($urandom);
        load_phase(256, 1'b1, 1000, 8);
        n_cmp++;
        if (o_we[0] !== 1'b1 || obs.size() != 0) begin
            n_err++; $display("FAIL midwrite_reached: got we=%b writes=%0d, want we=1 writes=0", o_we[0], obs.size());
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (o_all !== '0) begin
            n_err++; $display("FAIL midwrite_reset_outputs: got %h, want 0", o_all);
        end
        @(negedge clock); reset = 1'b1;
        load_phase(256, 1'b0, -1, 6000);
        run_phase(3, 100);
        n_cmp++;
        if (bound_hit || obs.size() != 64) begin
            n_err++; $display("FAIL midwrite_reload_count: got writes=%0d bound=%0d, want 64/0", obs.size(), bound_hit);
        end
        e = model_write(0, 256, 10'd0);
        n_cmp++;
        if (obs.size() == 0 || obs[0] !== e) begin
            n_err++; $display("FAIL midwrite_reload_first: got writes=%0d, want first %h", obs.size(), e);
        end
        n_cmp++;
        if (o_cc !== 32'd4 || o_run_done !== 1'b1) begin
            n_err++; $display("FAIL midwrite_reload_cc: got cc=%0d done=%b, want cc=4 done=1", o_cc, o_run_done);
        end
    endtask

    initial begin
        test_reset();
        test_load_256();
        test_partial_word();
        test_timeout();
        test_stall();
        test_random_wrap();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
